alu_operand_loader: RTL and testbench

- Front-end that drives the combinational ALU on the Basys3 board from slide switches and push buttons.
- Each button is synchronized, debounced and edge-detected, then latches the switch value into operand 1, operand 2 or the opcode register.
- Those registers drive the ALU's i_op_1/i_op_2/i_opcode.
- ALU o_result is sampled back and registered for the LEDs, with a one-cycle valid strobe.

---
 rtl/alu_operand_loader.sv | 168 ++++++++++++++++
 tb/tb_alu_operand_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_loader.sv
// alu_operand_loader
//
// Front-end for a combinational ALU on a Basys3 board. Three raw push buttons
// are each synchronized, debounced and edge-detected; a rising debounced edge
// latches the slide switches into operand 1, operand 2 or the opcode register.
// Those registers drive the ALU inputs. After each load the ALU gets one full
// settle cycle, and its result is then captured for the LEDs with a one-cycle
// valid strobe.
//
// Optional feature: define ALU_LOADER_FLAGS_EN to add the o_zero / o_neg flag
// outputs, captured together with o_result.
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous, active-high reset
//   i_sw           slide switches, data to load
//   i_btn_op1      raw button, load operand 1
//   i_btn_op2      raw button, load operand 2
//   i_btn_opcode   raw button, load opcode
//   i_alu_result   ALU result feedback
//   o_op_1         to ALU operand 1
//   o_op_2         to ALU operand 2
//   o_opcode       to ALU opcode
//   o_zero         (flags build only) captured result == 0
//   o_neg          (flags build only) captured result MSB
//   o_result       registered ALU result for the LEDs
//   o_valid        one-cycle strobe, o_result just updated
module alu_operand_loader #(
    parameter int unsigned NB_DATA   = 8,
    parameter int unsigned NB_OPCODE = 6,
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned NB_DB_CNT = 20
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NB_DATA-1:0]   i_sw,
    input  logic                 i_btn_op1,
    input  logic                 i_btn_op2,
    input  logic                 i_btn_opcode,
    input  logic [NB_DATA-1:0]   i_alu_result,
    output logic [NB_DATA-1:0]   o_op_1,
    output logic [NB_DATA-1:0]   o_op_2,
    output logic [NB_OPCODE-1:0] o_opcode,
`ifdef ALU_LOADER_FLAGS_EN
    output logic                 o_zero,
    output logic                 o_neg,
`endif
    output logic [NB_DATA-1:0]   o_result,
    output logic                 o_valid
);

    localparam int unsigned NB_BTN = 3;
    localparam logic [NB_DB_CNT-1:0] DB_LAST = NB_DB_CNT'(DB_CYCLES - 1);

    // Button index: 0 = op1, 1 = op2, 2 = opcode
    logic [NB_BTN-1:0]    btn_raw;
    logic [NB_BTN-1:0]    sync_meta;
    logic [NB_BTN-1:0]    sync_lvl;
    logic [1:0]           sync_fill;
    logic [NB_BTN-1:0]    db_lvl;
    logic [NB_BTN-1:0]    db_prev;
    logic [NB_BTN-1:0]    armed;
    logic [NB_DB_CNT-1:0] db_cnt [NB_BTN];
    logic [NB_BTN-1:0]    load_pulse;
    logic                 any_load;

    assign btn_raw = {i_btn_opcode, i_btn_op2, i_btn_op1};

    // ------------------------------------------------------------------
    // Input conditioning: 2-FF sync, debounce counter, edge detect state
    // ------------------------------------------------------------------
    // sync_fill marks when the synchronizer holds real samples again after
    // reset. A button is only armed once it has been seen released with a
    // valid synchronized sample, so a button held through reset cannot
    // produce a load until it is released and pressed again.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_meta <= '0;
            sync_lvl  <= '0;
            sync_fill <= '0;
            db_lvl    <= '0;
            db_prev   <= '0;
            armed     <= '0;
            for (int i = 0; i < NB_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_meta <= btn_raw;
            sync_lvl  <= sync_meta;
            sync_fill <= {sync_fill[0], 1'b1};
            db_prev   <= db_lvl;
            for (int i = 0; i < NB_BTN; i++) begin
                if (sync_lvl[i] != db_lvl[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db_lvl[i] <= sync_lvl[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + NB_DB_CNT'(1);
                    end
                end else begin
                    // Level agrees again: any partial count was a glitch
                    db_cnt[i] <= '0;
                end
                if (sync_fill[1] && !sync_lvl[i]) begin
                    armed[i] <= 1'b1;
                end
            end
        end
    end

    // Rising debounced edge only; release gives no pulse
    assign load_pulse = db_lvl & ~db_prev & armed;
    assign any_load   = |load_pulse;

    // ------------------------------------------------------------------
    // Operand registers and capture FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCapture
    } state_e;

    state_e state;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= StIdle;
            o_op_1   <= '0;
            o_op_2   <= '0;
            o_opcode <= '0;
            o_result <= '0;
            o_valid  <= 1'b0;
`ifdef ALU_LOADER_FLAGS_EN
            o_zero   <= 1'b0;
            o_neg    <= 1'b0;
`endif
        end else begin
            o_valid <= 1'b0;

            // Simultaneous pulses load independently
            if (load_pulse[0]) o_op_1   <= i_sw;
            if (load_pulse[1]) o_op_2   <= i_sw;
            if (load_pulse[2]) o_opcode <= i_sw[NB_OPCODE-1:0];

            if (any_load) begin
                // A fresh load restarts settling and drops any capture in flight
                state <= StSettle;
            end else begin
                case (state)
                    StIdle:    state <= StIdle;
                    StSettle:  state <= StCapture;
                    StCapture: begin
                        o_result <= i_alu_result;
                        o_valid  <= 1'b1;
`ifdef ALU_LOADER_FLAGS_EN
                        o_zero   <= (i_alu_result == '0);
                        o_neg    <= i_alu_result[NB_DATA-1];
`endif
                        state    <= StIdle;
                    end
                    default:   state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Testbench for alu_operand_loader with a behavioural ALU as feedback.
// Expected results are queued when a button press is issued; a monitor pops
// and compares them whenever o_valid is seen.
module tb_alu_operand_loader;

    localparam int unsigned NB_DATA   = 8;
    localparam int unsigned NB_OPCODE = 6;
    localparam int unsigned DB_CYCLES = 4;
    localparam int unsigned NB_DB_CNT = 3;
    // press -> valid: 2 sync + DB_CYCLES debounce + pulse/load + settle + capture
    localparam int unsigned LAT = 2 + DB_CYCLES + 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NB_DATA-1:0]   sw;
    logic [2:0]           btn;
    logic [NB_DATA-1:0]   alu_result;
    logic [NB_DATA-1:0]   op_1;
    logic [NB_DATA-1:0]   op_2;
    logic [NB_OPCODE-1:0] opcode;
    logic [NB_DATA-1:0]   result;
    logic                 valid;
`ifdef ALU_LOADER_FLAGS_EN
    logic                 zero;
    logic                 neg;
`endif

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    logic        valid_prev = 1'b0;

    typedef struct {
        logic [7:0]  res;
        logic        zero;
        logic        neg;
        int unsigned cyc;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Behavioural ALU
    always_comb begin
        alu_result = '0;
        case (opcode)
            6'h20:   alu_result = op_1 + op_2;
            6'h22:   alu_result = op_1 - op_2;
            6'h24:   alu_result = op_1 & op_2;
            6'h25:   alu_result = op_1 | op_2;
            6'h26:   alu_result = op_1 ^ op_2;
            6'h27:   alu_result = ~(op_1 | op_2);
            default: alu_result = '0;
        endcase
    end

    alu_operand_loader #(
        .NB_DATA   (NB_DATA),
        .NB_OPCODE (NB_OPCODE),
        .DB_CYCLES (DB_CYCLES),
        .NB_DB_CNT (NB_DB_CNT)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_sw         (sw),
        .i_btn_op1    (btn[0]),
        .i_btn_op2    (btn[1]),
        .i_btn_opcode (btn[2]),
        .i_alu_result (alu_result),
        .o_op_1       (op_1),
        .o_op_2       (op_2),
        .o_opcode     (opcode),
`ifdef ALU_LOADER_FLAGS_EN
        .o_zero       (zero),
        .o_neg        (neg),
`endif
        .o_result     (result),
        .o_valid      (valid)
    );

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (valid) begin
            check("valid_not_back_to_back", int'(valid_prev), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", int'(result), int'(e.res));
                check("valid_cycle", int'(cyc), int'(e.cyc));
`ifdef ALU_LOADER_FLAGS_EN
                check("zero_flag", int'(zero), int'(e.zero));
                check("neg_flag", int'(neg), int'(e.neg));
`endif
            end
        end
        valid_prev <= valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mask: bit0 op1, bit1 op2, bit2 opcode
    task automatic press(input logic [2:0] mask, input logic [7:0] sw_val, input int hold,
                         input logic do_exp, input logic [7:0] res, input logic z,
                         input logic n);
        exp_t e;
        tick(1);
        sw  = sw_val;
        btn = mask;
        if (do_exp) begin
            e.res  = res;
            e.zero = z;
            e.neg  = n;
            e.cyc  = cyc + LAT;
            exp_q.push_back(e);
        end
        tick(hold);
        btn = '0;
        tick(14);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_op_1"}, int'(op_1), 0);
        check({tag, "_op_2"}, int'(op_2), 0);
        check({tag, "_opcode"}, int'(opcode), 0);
        check({tag, "_result"}, int'(result), 0);
        check({tag, "_valid"}, int'(valid), 0);
`ifdef ALU_LOADER_FLAGS_EN
        check({tag, "_zero"}, int'(zero), 0);
        check({tag, "_neg"}, int'(neg), 0);
`endif
    endtask

    initial begin
        // Reset with random inputs
        reset = 1'b1;
        btn   = 3'($urandom);
        sw    = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            btn = 3'($urandom);
            sw  = 8'($urandom);
        end
        reset = 1'b0;
        btn   = '0;
        sw    = '0;
        check_all_zero("reset");
        tick(10);

        // Load sequence, each button held 12 cycles
        press(3'b001, 8'h01, 12, 1'b1, 8'h00, 1'b1, 1'b0);
        press(3'b010, 8'h01, 12, 1'b1, 8'h00, 1'b1, 1'b0);
        press(3'b100, 8'h20, 12, 1'b1, 8'h02, 1'b0, 1'b0);
        check("seq_op_1", int'(op_1), 8'h01);
        check("seq_op_2", int'(op_2), 8'h01);
        check("seq_opcode", int'(opcode), 6'h20);
        check("seq_result", int'(result), 8'h02);

        // Bounce rejection
        sw = 8'hAA;
        for (int i = 0; i < 10; i++) begin
            btn[0] = ~btn[0];
            tick(2);
        end
        btn[0] = 1'b0;
        tick(20);
        check("bounce_op_1", int'(op_1), 8'h01);

        // Held button: op1=4, op2=5, SUB held 100 cycles
        press(3'b001, 8'h04, 12, 1'b1, 8'h05, 1'b0, 1'b0);
        press(3'b010, 8'h05, 12, 1'b1, 8'h09, 1'b0, 1'b0);
        press(3'b100, 8'h22, 100, 1'b1, 8'hFF, 1'b0, 1'b1);
        check("held_opcode", int'(opcode), 6'h22);
        check("held_result", int'(result), 8'hFF);

        // Simultaneous op1/op2 with XOR
        press(3'b100, 8'h26, 12, 1'b1, 8'h01, 1'b0, 1'b0);
        press(3'b011, 8'h0F, 12, 1'b1, 8'h00, 1'b1, 1'b0);
        check("simul_op_1", int'(op_1), 8'h0F);
        check("simul_op_2", int'(op_2), 8'h0F);
        check("simul_result", int'(result), 8'h00);

        // Reset during a debounce count (counter reaches 2 after 4 edges)
        tick(1);
        sw     = 8'h33;
        btn[0] = 1'b1;
        tick(4);
        reset  = 1'b1;
        tick(2);
        reset  = 1'b0;
        check_all_zero("rst_db");
        tick(30);
        check("rst_db_held_op_1", int'(op_1), 0);
        btn[0] = 1'b0;
        tick(14);
        press(3'b001, 8'h33, 12, 1'b1, 8'h00, 1'b1, 1'b0);
        check("rst_db_repress_op_1", int'(op_1), 8'h33);

        // Reset while in SETTLE
        tick(1);
        sw     = 8'h44;
        btn[1] = 1'b1;
        tick(7);
        check("settle_load_op_2", int'(op_2), 8'h44);
        reset  = 1'b1;
        tick(2);
        reset  = 1'b0;
        check_all_zero("rst_settle");
        tick(20);
        btn[1] = 1'b0;
        tick(15);
        check("rst_settle_op_2", int'(op_2), 0);

        tick(20);
        check("pending_expected", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
